// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID pipeline register: NOP encoding and the
// RUN/HOLD state encoding.
package if_id_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/if_id_perf.sv
// Saturating stall and flush event counters for the IF/ID stage.
// Only instantiated when IF_ID_PERF_EN is defined.
module if_id_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        keep_i,
  input  logic        back_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // A redirect on the same edge as a stall counts only as a flush.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (back_i) begin
      if (flush_q != 32'hFFFF_FFFF) flush_d = flush_q + 32'd1;
    end else if (keep_i) begin
      if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: rtl/if_id.sv
// IF/ID pipeline register with stall hold buffer and redirect flush.
// Optional perf counters are enabled by defining IF_ID_PERF_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | decode instruction comes straight from the registered IROM
// ST_HOLD | IROM data has moved on; decode shows the captured hold_q
module if_id
  import if_id_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_if_i,
  input  logic [31:0] pc4_if_i,
  input  logic [31:0] inst_i,
  input  logic        keep_i,
  input  logic        back_i,
  output logic [31:0] pc_id_o,
  output logic [31:0] pc4_id_o,
  output logic [31:0] inst_id_o,
  output logic        valid_id_o,
  output logic        misalign_id_o
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        misalign;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    if (back_i) begin
      pc_d    = pc_if_i;
      pc4_d   = pc4_if_i;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (keep_i) begin
      // Capture only on the first stall edge; later edges see stale IROM data.
      if (state_q == ST_RUN) begin
        hold_d  = inst_i;
        state_d = ST_HOLD;
      end
    end else begin
      pc_d    = pc_if_i;
      pc4_d   = pc4_if_i;
      valid_d = 1'b1;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      pc4_q   <= '0;
      hold_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign misalign = valid_q & (pc_q[1:0] != 2'b00);

  always_comb begin
    if (!valid_q || misalign) inst_id_o = NOP;
    else if (state_q == ST_HOLD) inst_id_o = hold_q;
    else inst_id_o = inst_i;
  end

  assign pc_id_o       = pc_q;
  assign pc4_id_o      = pc4_q;
  assign valid_id_o    = valid_q;
  assign misalign_id_o = misalign;

`ifdef IF_ID_PERF_EN
  if_id_perf u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .keep_i      (keep_i),
    .back_i      (back_i),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_if_id.sv
// Self-checking bench for if_id: directed scenarios plus a randomized run
// against a slot-level model of the decode register.
module tb_if_id;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, keep, back;
  logic [31:0] pc_if, pc4_if, inst;
  logic [31:0] pc_id, pc4_id, inst_id;
  logic        valid_id, misalign;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model of what the decode slot should show.
  logic [31:0] m_pc, m_pc4, m_frozen;
  logic        m_valid;
  logic        m_live;     // decode shows current IROM data (not frozen)
  longint      m_stall, m_flush;

  if_id dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_if_i       (pc_if),
    .pc4_if_i      (pc4_if),
    .inst_i        (inst),
    .keep_i        (keep),
    .back_i        (back),
    .pc_id_o       (pc_id),
    .pc4_id_o      (pc4_id),
    .inst_id_o     (inst_id),
    .valid_id_o    (valid_id),
    .misalign_id_o (misalign)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [97:0] model_vec();
    logic [31:0] ei;
    logic        mis;
    mis = m_valid && (m_pc[1:0] != 2'b00);
    if (!m_valid || mis) ei = NOP;
    else if (m_live) ei = inst;
    else ei = m_frozen;
    return {m_pc, m_pc4, ei, m_valid, mis};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {pc_id, pc4_id, inst_id, valid_id, misalign};
  endfunction

  // One clock edge; afterwards the IROM presents next_inst for the new PC.
  task automatic tick(input logic [31:0] next_inst);
    logic s_rst, s_keep, s_back;
    logic [31:0] s_pc, s_pc4, s_inst;
    s_rst = rst; s_keep = keep; s_back = back;
    s_pc = pc_if; s_pc4 = pc4_if; s_inst = inst;
    @(posedge clk);
    if (s_rst) begin
      m_pc = '0; m_pc4 = '0; m_valid = 1'b0; m_live = 1'b1; m_frozen = NOP;
      m_stall = 0; m_flush = 0;
    end else begin
      if (s_back) m_flush = (m_flush < 64'hFFFF_FFFF) ? m_flush + 1 : m_flush;
      else if (s_keep) m_stall = (m_stall < 64'hFFFF_FFFF) ? m_stall + 1 : m_stall;
      if (s_back) begin
        m_pc = s_pc; m_pc4 = s_pc4; m_valid = 1'b0; m_live = 1'b1;
      end else if (s_keep) begin
        if (m_live) begin
          m_frozen = s_inst; m_live = 1'b0;
        end
      end else begin
        m_pc = s_pc; m_pc4 = s_pc4; m_valid = 1'b1; m_live = 1'b1;
      end
    end
    #1;
    inst = next_inst;
    #1;
  endtask

  task automatic drive(input logic r, input logic k, input logic b, input logic [31:0] pc);
    rst = r; keep = k; back = b; pc_if = pc; pc4_if = pc + 32'd4;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_1234);
    tick(32'hCAFE_0001);
    tick(32'hCAFE_0002);
    total++;
    if (dut_vec() !== {32'h0, 32'h0, NOP, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got pc=%h pc4=%h inst=%h v=%b mis=%b, need 0/0/%h/0/0",
               pc_id, pc4_id, inst_id, valid_id, misalign, NOP);
    end
`ifdef IF_ID_PERF_EN
    total++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d, need 0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_advance();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    tick(32'h0050_0093);
    total++;
    if (dut_vec() !== {32'h0, 32'h4, 32'h0050_0093, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL advance: got pc=%h pc4=%h inst=%h v=%b, need 0/4/00500093/1",
               pc_id, pc4_id, inst_id, valid_id);
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0010);
    tick(32'h0020_8133);
    total++;
    if (pc_id !== 32'h10 || inst_id !== 32'h0020_8133) begin
      bad++;
      $display("FAIL stall_setup: got pc=%h inst=%h, need 10/00208133", pc_id, inst_id);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0014);
    for (int i = 0; i < 3; i++) begin
      tick(32'hDEAD_BEEF);
      total++;
      if (pc_id !== 32'h10 || pc4_id !== 32'h14 || inst_id !== 32'h0020_8133 || valid_id !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h pc4=%h inst=%h v=%b, need 10/14/00208133/1",
                 i, pc_id, pc4_id, inst_id, valid_id);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0014);
    tick(32'h00C0_0193);
    total++;
    if (pc_id !== 32'h14 || inst_id !== 32'h00C0_0193 || valid_id !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: got pc=%h inst=%h v=%b, need 14/00c00193/1", pc_id, inst_id, valid_id);
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    tick(32'h1111_1111);
    total++;
    if (valid_id !== 1'b0 || inst_id !== NOP || pc_id !== 32'h40) begin
      bad++;
      $display("FAIL flush: got v=%b inst=%h pc=%h, need 0/%h/40", valid_id, inst_id, pc_id, NOP);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0044);
    tick(32'h2222_2222);
    total++;
    if (valid_id !== 1'b1 || inst_id !== 32'h2222_2222) begin
      bad++;
      $display("FAIL flush_recover: got v=%b inst=%h, need 1/22222222", valid_id, inst_id);
    end
  endtask

  task automatic test_back_keep_in_hold();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0100);
    tick(32'h3333_3333);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0104);
    tick(32'h4444_4444);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    tick(32'h5555_5555);
    total++;
    if (valid_id !== 1'b0 || inst_id !== NOP || pc_id !== 32'h200) begin
      bad++;
      $display("FAIL back_keep: got v=%b inst=%h pc=%h, need 0/%h/200", valid_id, inst_id, pc_id, NOP);
    end
`ifdef IF_ID_PERF_EN
    total++;
    if (stall_cnt !== m_stall[31:0] || flush_cnt !== m_flush[31:0]) begin
      bad++;
      $display("FAIL back_keep_cnt: got stall=%0d flush=%0d, need %0d/%0d",
               stall_cnt, flush_cnt, m_stall, m_flush);
    end
`endif
    // Back in RUN: decode must follow live IROM data, not the old capture.
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0204);
    tick(32'h6666_6666);
    total++;
    if (valid_id !== 1'b1 || inst_id !== 32'h6666_6666) begin
      bad++;
      $display("FAIL back_keep_run: got v=%b inst=%h, need 1/66666666", valid_id, inst_id);
    end
  endtask

  task automatic test_misalign();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0006);
    tick(32'h7777_7777);
    total++;
    if (misalign !== 1'b1 || inst_id !== NOP || valid_id !== 1'b1 || pc_id !== 32'h6) begin
      bad++;
      $display("FAIL misalign: got mis=%b inst=%h v=%b pc=%h, need 1/%h/1/6",
               misalign, inst_id, valid_id, pc_id, NOP);
    end
  endtask

  task automatic test_reset_in_hold();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0300);
    tick(32'h8888_8888);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0304);
    tick(32'h9999_9999);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0304);
    tick(32'hAAAA_AAAA);
    total++;
    if (dut_vec() !== {32'h0, 32'h0, NOP, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold: got pc=%h pc4=%h inst=%h v=%b mis=%b, need 0/0/%h/0/0",
               pc_id, pc4_id, inst_id, valid_id, misalign, NOP);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0400);
    tick(32'hBBBB_BBBB);
    total++;
    if (inst_id !== 32'hBBBB_BBBB || valid_id !== 1'b1 || pc_id !== 32'h400) begin
      bad++;
      $display("FAIL reset_hold_release: got inst=%h v=%b pc=%h, need bbbbbbbb/1/400",
               inst_id, valid_id, pc_id);
    end
  endtask

  task automatic test_random();
    logic [97:0] exp_v;
    logic [31:0] pc;
    for (int i = 0; i < 600; i++) begin
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      pc = pc << 0;
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2, pc);
      tick($urandom);
      exp_v = model_vec();
      total++;
      if (dut_vec() !== exp_v) begin
        bad++;
        $display("FAIL random[%0d]: got pc/pc4/inst/v/mis=%h, need %h", i, dut_vec(), exp_v);
      end
`ifdef IF_ID_PERF_EN
      total++;
      if (stall_cnt !== m_stall[31:0] || flush_cnt !== m_flush[31:0]) begin
        bad++;
        $display("FAIL random_cnt[%0d]: got stall=%0d flush=%0d, need %0d/%0d",
                 i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; keep = 1'b0; back = 1'b0;
    pc_if = '0; pc4_if = 32'd4; inst = NOP;
    m_pc = '0; m_pc4 = '0; m_valid = 1'b0; m_live = 1'b1; m_frozen = NOP;
    m_stall = 0; m_flush = 0;
    test_reset();
    test_advance();
    test_stall();
    test_flush();
    test_back_keep_in_hold();
    test_misalign();
    test_reset_in_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk_i  input  1  clock, all state on rising edge; rst_i  input  1  synchronous active-high reset.
REQ-002 Fetch-side inputs SHALL be: pc_if_i  input  32  fetch PC; pc4_if_i  input  32  fetch PC+4; inst_i  input  32  registered IROM read data for the PC sampled at the previous edge.
REQ-003 Control inputs SHALL be: keep_i  input  1  stall from hazard unit; back_i  input  1  redirect/flush from branch resolution.
REQ-004 Decode-side outputs SHALL be: pc_id_o  output  32; pc4_id_o  output  32; inst_id_o  output  32; valid_id_o  output  1  slot holds a real instruction; misalign_id_o  output  1  pc_id_o[1:0] != 0 while valid.
REQ-005 When IF_ID_PERF_EN is defined, the block SHALL add: stall_cnt_o  output  32; flush_cnt_o  output  32.

Function
REQ-006 The block SHALL implement a two-state machine: RUN (inst_id_o from inst_i) and HOLD (inst_id_o from an internal 32-bit hold register).
REQ-007 Edge priority SHALL be rst_i > back_i > keep_i > normal advance.
REQ-008 Normal advance (no back_i, no keep_i): pc_id_o<=pc_if_i, pc4_id_o<=pc4_if_i, valid_id_o<=1, state<=RUN.
REQ-009 back_i edge: pc_id_o/pc4_id_o load from IF, valid_id_o<=0, state<=RUN, hold register unchanged.
REQ-010 keep_i edge in RUN: pc_id_o, pc4_id_o, valid_id_o hold; hold register<=inst_i; state<=HOLD.
REQ-011 keep_i edge in HOLD: all registers hold; state stays HOLD.
REQ-012 Release from HOLD (keep_i low, back_i low) SHALL perform a normal advance and return to RUN; no instruction is duplicated or dropped.
REQ-013 inst_id_o SHALL be combinational: NOP when valid_id_o=0; inst_i in RUN; hold register in HOLD.
REQ-014 misalign_id_o SHALL equal valid_id_o & (pc_id_o[1:0] != 2'b00); when set, inst_id_o SHALL be NOP.
REQ-015 Latency SHALL be one cycle from pc_if_i sampling to pc_id_o/inst_id_o presentation.
REQ-016 back_i and keep_i asserted together SHALL behave as back_i alone, including leaving HOLD.

Reset
REQ-017 On an rst_i edge: pc_id_o=0, pc4_id_o=0, valid_id_o=0, state=RUN, hold register=NOP; consequently inst_id_o=NOP, misalign_id_o=0.
REQ-018 rst_i asserted in HOLD SHALL abandon the held instruction with no residue after release.
REQ-019 Performance counters, when present, SHALL reset to 0 with rst_i.

Configuration
REQ-020 Macro IF_ID_PERF_EN defined: stall_cnt_o increments on every edge with keep_i=1 and back_i=0; flush_cnt_o increments on every edge with back_i=1; both saturate at 32'hFFFF_FFFF.
REQ-021 Macro IF_ID_PERF_EN undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-022 The NOP encoding (32'h0000_0013) and the RUN/HOLD state encodings SHALL live in the shared defines file.
REQ-023 The counters SHALL form one sub-module, if_id_perf, instantiated only under IF_ID_PERF_EN.

Verification
REQ-024 Reset then pc_if_i=0x0000_0000, inst_i=0x0050_0093 advancing -> after the next edge: valid_id_o=1, pc_id_o=0, pc4_id_o=4, inst_id_o=0x0050_0093.
REQ-025 Stall 3 cycles with pc_id_o=0x10, inst=0x0020_8133 while inst_i is driven 0xDEAD_BEEF -> inst_id_o stays 0x0020_8133 for all 3 cycles; on release pc_id_o=0x14 with inst_i.
REQ-026 back_i for one edge with pc_if_i=0x40 -> valid_id_o=0, inst_id_o=0x0000_0013; next advance gives valid_id_o=1.
REQ-027 back_i and keep_i high together while in HOLD -> state RUN, valid_id_o=0; with IF_ID_PERF_EN, flush_cnt_o +1 and stall_cnt_o unchanged.
REQ-028 pc_if_i=0x0000_0006 advanced -> misalign_id_o=1, inst_id_o=NOP; rst_i during HOLD -> all outputs at reset values next cycle.
